// File: rtl/fetch_unit.sv
// 6502 instruction-fetch unit: reset-vector fetch, then sequential opcode prefetch into a
// DEPTH-entry queue presented to decode through a valid/ready handshake, with redirect flush.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] AD,
  output logic              RW,
  input  logic [7:0]        D_in,
  input  logic              mem_rdy,
  output logic              ib_valid,
  output logic [7:0]        ib_data,
  output logic [ADDR_W-1:0] ib_pc,
  input  logic              ib_ready,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [ADDR_W-1:0] VecHi = RESET_VEC + ADDR_W'(1);

  typedef enum logic [1:0] {StVlo, StVhi, StVld, StRun} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fpc;
  logic [7:0]        r_lo;
  logic              r_inflight;
  logic [7:0]        r_qdata [DEPTH];
  logic [ADDR_W-1:0] r_qpc   [DEPTH];
  logic [PtrW-1:0]   r_wr;
  logic [PtrW-1:0]   r_rd;
  logic [CntW-1:0]   r_count;

  logic            w_pop;
  logic            w_redir;
  logic            w_push;
  logic            w_room;
  logic            w_issue;
  logic [OccW-1:0] w_occ;

  assign w_pop   = ib_valid & ib_ready;
  assign w_redir = redir & (r_state == StRun);
  assign w_push  = r_inflight & (r_state == StRun) & ~w_redir;
  // Occupancy after this edge's pop, counting the read whose byte is still on its way.
  assign w_occ   = {1'b0, r_count} + OccW'(r_inflight) - OccW'(w_pop);
  assign w_room  = w_occ < OccW'(DEPTH);
  assign w_issue = mem_rdy & ((r_state == StVlo) | (r_state == StVhi) |
                              ((r_state == StRun) & w_room & ~w_redir));

  always_comb begin
    AD = r_pc;
    case (r_state)
      StVlo:   AD = RESET_VEC;
      StVhi:   AD = VecHi;
      StVld:   AD = VecHi;
      default: AD = r_pc;
    endcase
  end

  assign RW       = 1'b1;
  assign ib_valid = (r_count != '0);
  assign ib_data  = r_qdata[r_rd];
  assign ib_pc    = r_qpc[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StVlo;
      r_pc       <= '0;
      r_fpc      <= '0;
      r_lo       <= '0;
      r_inflight <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_qdata[i] <= '0;
        r_qpc[i]   <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        StVlo: if (w_issue) r_state <= StVhi;
        StVhi: begin
          if (r_inflight) r_lo <= D_in;
          if (w_issue) r_state <= StVld;
        end
        StVld: begin
          r_pc    <= ADDR_W'({D_in, r_lo});
          r_state <= StRun;
        end
        default: begin
          if (w_redir) begin
            // Dropping the push discards the byte of any read already on the bus.
            r_pc    <= redir_pc;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
          end else begin
            if (w_issue) begin
              r_pc  <= r_pc + ADDR_W'(1);
              r_fpc <= r_pc;
            end
            if (w_push) begin
              r_qdata[r_wr] <= D_in;
              r_qpc[r_wr]   <= r_fpc;
              r_wr          <= r_wr + PtrW'(1);
            end
            if (w_pop) r_rd <= r_rd + PtrW'(1);
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector fetch, backpressure, redirects, random wait states,
// PC wrap and mid-stream reset, checked against a behavioural memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] AD;
  logic        RW;
  logic [7:0]  D_in = 8'h00;
  logic        mem_rdy = 1'b1;
  logic        ib_valid;
  logic [7:0]  ib_data;
  logic [15:0] ib_pc;
  logic        ib_ready = 1'b0;
  logic        redir = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        rand_en = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(16), .DEPTH(4), .RESET_VEC(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .AD(AD), .RW(RW), .D_in(D_in), .mem_rdy(mem_rdy),
    .ib_valid(ib_valid), .ib_data(ib_data), .ib_pc(ib_pc), .ib_ready(ib_ready),
    .redir(redir), .redir_pc(redir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'h80;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Memory returns the byte for the address seen at each edge on the following cycle.
  always @(posedge clk) D_in <= memf(AD);

  always @(negedge clk) mem_rdy = rand_en ? 1'($urandom) : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for a head byte, accepts it on the next edge and checks address and data.
  task automatic pop_expect(input logic [15:0] a);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      ib_ready = ib_valid;
      if (ib_valid) got = 1'b1;
    end
    check("pop_valid", 32'(got), 32'd1);
    if (got) begin
      check("pop_pc", 32'(ib_pc), 32'(a));
      check("pop_data", 32'(ib_data), 32'(memf(a)));
    end
  endtask

  // Called at a negedge; the redirect edge coincides with any pop left armed by pop_expect.
  task automatic do_redir(input logic [15:0] pc);
    redir    = 1'b1;
    redir_pc = pc;
    @(negedge clk);
    redir    = 1'b0;
    ib_ready = 1'b0;
    check("redir_valid", 32'(ib_valid), 32'd0);
    check("redir_ad", 32'(AD), 32'(pc));
  endtask

  initial begin
    #2;
    check("rst_ad", 32'(AD), 32'h0000FFFC);
    check("rst_rw", 32'(RW), 32'd1);
    check("rst_valid", 32'(ib_valid), 32'd0);
    check("rst_data", 32'(ib_data), 32'd0);
    check("rst_pc", 32'(ib_pc), 32'd0);

    // Vector fetch and backpressure with ib_ready low
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("vlo_ad", 32'(AD), 32'h0000FFFC);
    @(negedge clk);
    check("vhi_ad", 32'(AD), 32'h0000FFFD);
    @(negedge clk);
    @(negedge clk);
    check("run_ad0", 32'(AD), 32'h00008000);
    @(negedge clk);
    check("run_ad1", 32'(AD), 32'h00008001);
    repeat (4) @(negedge clk);
    check("full_ad", 32'(AD), 32'h00008004);
    @(negedge clk);
    check("full_ad_hold", 32'(AD), 32'h00008004);
    check("full_valid", 32'(ib_valid), 32'd1);
    check("full_head_pc", 32'(ib_pc), 32'h00008000);
    @(negedge clk);
    check("hold_pc", 32'(ib_pc), 32'h00008000);
    check("hold_data", 32'(ib_data), 32'(memf(16'h8000)));
    for (int i = 0; i < 8; i++) pop_expect(16'h8000 + 16'(i));

    // Redirect with a read in flight and a simultaneous pop
    do_redir(16'h1234);
    for (int i = 0; i < 3; i++) pop_expect(16'h1234 + 16'(i));

    // Random wait states
    rand_en = 1'b1;
    do_redir(16'h4000);
    for (int i = 0; i < 64; i++) pop_expect(16'h4000 + 16'(i));
    rand_en = 1'b0;

    // PC wrap
    do_redir(16'hFFFE);
    pop_expect(16'hFFFE);
    pop_expect(16'hFFFF);
    pop_expect(16'h0000);
    pop_expect(16'h0001);
    @(negedge clk);
    ib_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", 32'(ib_valid), 32'd1);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ib_valid), 32'd0);
    check("arst_ad", 32'(AD), 32'h0000FFFC);
    check("arst_pc", 32'(ib_pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("re_vhi_ad", 32'(AD), 32'h0000FFFD);
    pop_expect(16'h8000);
    pop_expect(16'h8001);
    @(negedge clk);
    ib_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
